enemy_spawn_sched: RTL and testbench

Schedules spawns for a pool of NUM_SLOTS enemy instances of the walker type; each instance's own state machine handles movement, animation, collision and kill.
- Tracks per-slot life state, caps the number alive and enforces a respawn delay after a kill.
- Round-robin arbitrates ready slots onto a single spawn request channel with a valid/ack handshake.
- Sits between the game-state logic (is_start) and the enemy instances; also feeds kill/alive counts to the HUD.

---
 rtl/enemy_pkg.sv | 36 +++
 rtl/enemy_spawn_sched_rr_arbiter.sv | 38 +++
 rtl/enemy_spawn_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_enemy_spawn_sched.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy spawn scheduler.
//
// Contents:
//   slot_state_e    - per-slot life state (idle, ready, alive, waiting to respawn)
//   spawn_side_e    - which screen edge a spawn enters from
//   SCREEN_W        - visible screen width in pixels
//   DEFAULT_*       - default spawn coordinates
//   LFSR_SEED       - reset value of the optional spawn-side LFSR
//   lfsr_next()     - one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
package enemy_pkg;

    typedef enum logic [1:0] {
        SlotIdle  = 2'd0,
        SlotReady = 2'd1,
        SlotAlive = 2'd2,
        SlotWait  = 2'd3
    } slot_state_e;

    typedef enum logic {
        SideLeft  = 1'b0,
        SideRight = 1'b1
    } spawn_side_e;

    localparam int unsigned SCREEN_W        = 640;
    localparam int unsigned DEFAULT_LEFT_X  = 3;
    localparam int unsigned DEFAULT_RIGHT_X = SCREEN_W - 4;
    localparam int unsigned DEFAULT_SPAWN_Y = 380;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Shift toward the MSB; feedback from bits 8,6,5,4 (1-based) enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/enemy_spawn_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//
// Picks the first asserted request at or after ptr, wrapping past N-1 to 0.
//
// Ports:
//   req         in   N     request vector
//   ptr         in   IdxW  highest-priority index this cycle (must be < N)
//   grant       out  N     one-hot grant (all zero when nothing requested)
//   grant_idx   out  IdxW  index of the granted request
//   grant_valid out  1     any request granted
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx,
    output logic            grant_valid
);

    // Pass 0 scans [ptr, N-1]; pass 1 scans [0, N-1] and so covers the wrap.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!grant_valid && req[i] && (pass == 1 || i >= 32'(ptr))) begin
                    grant[i]    = 1'b1;
                    grant_idx   = IdxW'(i);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/enemy_spawn_sched.sv
// Enemy spawn scheduler for a pool of walker instances.
//
// Tracks per-slot life state, caps how many enemies are alive at once, holds a
// slot off for RESPAWN_TICKS scheduler ticks after a kill, and round-robins
// ready slots onto one valid/ack spawn request channel.
//
// Build option: define SPAWN_LFSR_EN to choose the spawn side from an 8-bit
// LFSR (seed 8'hA5, advancing every frame_clk) instead of strict left/right
// alternation starting on the left.
//
// Ports:
//   frame_clk    in   1          clock
//   reset        in   1          asynchronous, active-high
//   is_start     in   1          title screen: hold every slot idle
//   kill_in      in   NUM_SLOTS  per-slot kill level from the enemy instances
//   spawn_ack    in   NUM_SLOTS  per-slot acceptance of the current request
//   spawn_valid  out  1          spawn request pending
//   spawn_slot   out  3          slot being spawned
//   spawn_x      out  10         spawn x position
//   spawn_y      out  10         spawn y position
//   slot_alive   out  NUM_SLOTS  per-slot alive flags
//   alive_count  out  4          number of slots alive
//   kill_count   out  8          saturating kill total
module enemy_spawn_sched
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_SLOTS     = 4,
    parameter int unsigned MAX_ALIVE     = 3,
    parameter int unsigned TICK_DIV      = 4,
    parameter int unsigned RESPAWN_TICKS = 1000,
    parameter int unsigned LEFT_X        = DEFAULT_LEFT_X,
    parameter int unsigned RIGHT_X       = DEFAULT_RIGHT_X,
    parameter int unsigned SPAWN_Y       = DEFAULT_SPAWN_Y
) (
    input  logic                 frame_clk,
    input  logic                 reset,
    input  logic                 is_start,
    input  logic [NUM_SLOTS-1:0] kill_in,
    input  logic [NUM_SLOTS-1:0] spawn_ack,
    output logic                 spawn_valid,
    output logic [2:0]           spawn_slot,
    output logic [9:0]           spawn_x,
    output logic [9:0]           spawn_y,
    output logic [NUM_SLOTS-1:0] slot_alive,
    output logic [3:0]           alive_count,
    output logic [7:0]           kill_count
);

    localparam int unsigned TimerW = $clog2(RESPAWN_TICKS + 1) > 0 ?
                                     $clog2(RESPAWN_TICKS + 1) : 1;
    localparam int unsigned TickW  = $clog2(TICK_DIV + 1);

    slot_state_e          state_q [NUM_SLOTS];
    logic [TimerW-1:0]    timer_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] kill_prev_q;
    logic [7:0]           kill_count_q, kill_count_d;
    logic [2:0]           rr_ptr_q;
    logic                 valid_q;
    logic [2:0]           slot_q;
    logic [NUM_SLOTS-1:0] grant_q;
    logic [9:0]           x_q, y_q;
    logic [TickW-1:0]     tick_cnt_q;

    logic [NUM_SLOTS-1:0] kill_edge, ready_vec, alive_vec, arb_grant;
    logic [2:0]           arb_idx, next_ptr;
    logic                 arb_valid, ack_hit, do_grant, tick;
    logic [3:0]           alive_cnt;
    spawn_side_e          side_sel;

    // ---------------------------------------------------------------- tick
    assign tick = (tick_cnt_q == TickW'(TICK_DIV - 1));

    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------ slot summaries
    assign kill_edge = kill_in & ~kill_prev_q;

    always_comb begin
        ready_vec = '0;
        alive_vec = '0;
        alive_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            ready_vec[i] = (state_q[i] == SlotReady);
            alive_vec[i] = (state_q[i] == SlotAlive);
            alive_cnt    = alive_cnt + {3'b000, alive_vec[i]};
        end
    end

    // Only edges on currently alive slots count; several may land together.
    always_comb begin
        kill_count_d = kill_count_q;
        if (!is_start) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (kill_edge[i] && alive_vec[i] && kill_count_d != 8'hFF) begin
                    kill_count_d = kill_count_d + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------- arbiter
    rr_arbiter #(
        .N    (NUM_SLOTS),
        .IdxW (3)
    ) u_arb (
        .req         (ready_vec),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // grant_q remembers the one-hot of the pending request so acks on other
    // slots fall out of the mask.
    assign ack_hit  = valid_q && |(spawn_ack & grant_q);
    assign do_grant = !valid_q && !is_start && arb_valid && (alive_cnt < 4'(MAX_ALIVE));
    assign next_ptr = (32'(slot_q) >= NUM_SLOTS - 1) ? 3'd0 : slot_q + 3'd1;

    // --------------------------------------------------------- spawn side
`ifdef SPAWN_LFSR_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign side_sel = spawn_side_e'(lfsr_q[0]);
`else
    spawn_side_e side_q;

    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            side_q <= SideLeft;
        end else if (do_grant) begin
            side_q <= (side_q == SideLeft) ? SideRight : SideLeft;
        end
    end

    assign side_sel = side_q;
`endif

    // ------------------------------------------- slot FSMs + spawn channel
    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= SlotIdle;
                timer_q[i] <= '0;
            end
            kill_prev_q  <= '0;
            kill_count_q <= '0;
            rr_ptr_q     <= '0;
            valid_q      <= 1'b0;
            slot_q       <= '0;
            grant_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            kill_prev_q  <= kill_in;
            kill_count_q <= kill_count_d;
            if (is_start) begin
                // Back to the title screen: abandon everything but the kill tally.
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    state_q[i] <= SlotIdle;
                    timer_q[i] <= '0;
                end
                valid_q <= 1'b0;
                grant_q <= '0;
            end else begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    case (state_q[i])
                        SlotIdle: state_q[i] <= SlotReady;
                        SlotReady: begin
                            if (ack_hit && grant_q[i]) begin
                                state_q[i] <= SlotAlive;
                            end
                        end
                        SlotAlive: begin
                            if (kill_edge[i]) begin
                                state_q[i] <= SlotWait;
                                timer_q[i] <= TimerW'(RESPAWN_TICKS);
                            end
                        end
                        SlotWait: begin
                            // The tick that would take the timer to zero releases the slot.
                            if (tick) begin
                                if (timer_q[i] <= TimerW'(1)) begin
                                    state_q[i] <= SlotReady;
                                    timer_q[i] <= '0;
                                end else begin
                                    timer_q[i] <= timer_q[i] - 1'b1;
                                end
                            end
                        end
                        default: state_q[i] <= SlotIdle;
                    endcase
                end

                if (ack_hit) begin
                    valid_q  <= 1'b0;
                    grant_q  <= '0;
                    rr_ptr_q <= next_ptr;
                end else if (do_grant) begin
                    valid_q <= 1'b1;
                    slot_q  <= arb_idx;
                    grant_q <= arb_grant;
                    x_q     <= (side_sel == SideRight) ? 10'(RIGHT_X) : 10'(LEFT_X);
                    y_q     <= 10'(SPAWN_Y);
                end
            end
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_slot  = slot_q;
    assign spawn_x     = x_q;
    assign spawn_y     = y_q;
    assign slot_alive  = alive_vec;
    assign alive_count = alive_cnt;
    assign kill_count  = kill_count_q;

endmodule

// File: tb/tb_enemy_spawn_sched.sv
// Self-checking bench for enemy_spawn_sched (4 slots, 3 alive, short respawn).
module tb_enemy_spawn_sched;

    localparam int unsigned RESPAWN = 25;

    logic       frame_clk;
    logic       reset;
    logic       is_start;
    logic [3:0] kill_in;
    logic [3:0] spawn_ack;
    logic       spawn_valid;
    logic [2:0] spawn_slot;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic [3:0] slot_alive;
    logic [3:0] alive_count;
    logic [7:0] kill_count;

    enemy_spawn_sched #(
        .NUM_SLOTS     (4),
        .MAX_ALIVE     (3),
        .TICK_DIV      (4),
        .RESPAWN_TICKS (RESPAWN)
    ) dut (
        .frame_clk   (frame_clk),
        .reset       (reset),
        .is_start    (is_start),
        .kill_in     (kill_in),
        .spawn_ack   (spawn_ack),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .slot_alive  (slot_alive),
        .alive_count (alive_count),
        .kill_count  (kill_count)
    );

    typedef struct {
        logic [2:0] slot;
        logic [9:0] x;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_side;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   exp_kc   = 0;

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;
    always @(posedge frame_clk) cyc <= cyc + 1;

`ifdef SPAWN_LFSR_EN
    // Reference LFSR; lat_bit holds bit 0 from the cycle a grant was decided.
    logic [7:0] m_lfsr;
    logic       lat_bit;
    always @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            m_lfsr  <= 8'hA5;
            lat_bit <= 1'b1;
        end else begin
            if (!spawn_valid) lat_bit <= m_lfsr[0];
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end
`endif

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] slot);
        exp_t e;
        e.slot   = slot;
        e.x      = exp_side ? 10'd636 : 10'd3;
        exp_side = ~exp_side;
        exp_q.push_back(e);
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e.slot = 3'd7;
        e.x    = 10'd0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
`ifdef SPAWN_LFSR_EN
        e.x = lat_bit ? 10'd636 : 10'd3;
`endif
        return e;
    endfunction

    // Wait for a request, check it against the scoreboard, hold, then ack
    // (optionally with kills and a wrong-slot ack during the hold).
    task automatic serve(input int hold, input int max_wait, input bit wrong_ack,
                         input logic [3:0] kill_mask, output int seen_cyc);
        int         waited;
        exp_t       e;
        bit         unstable;
        logic [3:0] alive_snap;
        waited   = 0;
        seen_cyc = -1;
        while (spawn_valid !== 1'b1 && waited < max_wait) begin
            step();
            waited++;
        end
        checks++;
        if (spawn_valid !== 1'b1) begin
            $display("FAIL serve_timeout spawn_valid=%b required 1", spawn_valid);
            failures++;
            return;
        end
        seen_cyc = cyc;
        e = pop_exp();
        checks++;
        if (spawn_slot !== e.slot) begin
            $display("FAIL spawn_slot got=%0d exp=%0d", spawn_slot, e.slot);
            failures++;
        end
        checks++;
        if (spawn_x !== e.x) begin
            $display("FAIL spawn_x slot=%0d got=%0d exp=%0d", e.slot, spawn_x, e.x);
            failures++;
        end
        checks++;
        if (spawn_y !== 10'd380) begin
            $display("FAIL spawn_y got=%0d exp=380", spawn_y);
            failures++;
        end
        unstable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (wrong_ack && i == hold / 2) begin
                alive_snap = slot_alive;
                spawn_ack  = ~(4'b0001 << e.slot);
                step();
                spawn_ack  = '0;
                checks++;
                if (spawn_valid !== 1'b1 || slot_alive !== alive_snap) begin
                    $display("FAIL wrong_ack valid=%b alive=%b exp valid=1 alive=%b",
                             spawn_valid, slot_alive, alive_snap);
                    failures++;
                end
            end else begin
                step();
            end
            if (spawn_valid !== 1'b1 || spawn_slot !== e.slot || spawn_x !== e.x ||
                spawn_y !== 10'd380) unstable = 1'b1;
        end
        if (hold >= 10) begin
            checks++;
            if (unstable) begin
                $display("FAIL hold_stable valid=%b slot=%0d x=%0d exp valid=1 slot=%0d x=%0d",
                         spawn_valid, spawn_slot, spawn_x, e.slot, e.x);
                failures++;
            end
        end
        spawn_ack = 4'b0001 << e.slot;
        kill_in   = kill_mask;
        step();
        spawn_ack = '0;
        kill_in   = '0;
        checks++;
        if (spawn_valid !== 1'b0 || slot_alive[e.slot] !== 1'b1) begin
            $display("FAIL ack_accept valid=%b alive=%b exp valid=0 alive[%0d]=1",
                     spawn_valid, slot_alive, e.slot);
            failures++;
        end
    endtask

    task automatic test_reset();
        bit saw_valid;
        reset     = 1'b1;
        is_start  = 1'b1;
        kill_in   = '0;
        spawn_ack = '0;
        exp_side  = 1'b0;
        repeat (3) step();
        checks++;
        if ({spawn_valid, spawn_slot, spawn_x, spawn_y, slot_alive, alive_count, kill_count}
            !== '0) begin
            $display("FAIL reset_outputs valid=%b slot=%0d x=%0d y=%0d alive=%b cnt=%0d kc=%0d",
                     spawn_valid, spawn_slot, spawn_x, spawn_y, slot_alive, alive_count,
                     kill_count);
            failures++;
        end
        reset = 1'b0;
        saw_valid = 1'b0;
        repeat (20) begin
            step();
            if (spawn_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || alive_count !== 4'd0) begin
            $display("FAIL start_screen_idle saw_valid=%b alive_count=%0d exp 0/0",
                     saw_valid, alive_count);
            failures++;
        end
    endtask

    task automatic test_initial_spawns();
        int c;
        bit saw_valid;
        is_start = 1'b0;
        push_exp(3'd0);
        push_exp(3'd1);
        push_exp(3'd2);
        for (int i = 0; i < 3; i++) serve(2, 20, 1'b0, 4'b0000, c);
        checks++;
        if (alive_count !== 4'd3 || slot_alive !== 4'b0111) begin
            $display("FAIL initial_alive count=%0d alive=%b exp 3/0111", alive_count, slot_alive);
            failures++;
        end
        saw_valid = 1'b0;
        repeat (30) begin
            step();
            if (spawn_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            $display("FAIL alive_cap spawn_valid seen=1 required 0 with 3 alive");
            failures++;
        end
    endtask

    task automatic test_kill_respawn();
        int t_kill1;
        int c;
        // Slot 3 is READY, not alive: its kill must not count.
        kill_in = 4'b1000;
        step();
        kill_in = '0;
        step();
        checks++;
        if (kill_count !== 8'(exp_kc)) begin
            $display("FAIL kill_non_alive kill_count=%0d exp=%0d", kill_count, exp_kc);
            failures++;
        end
        kill_in = 4'b0010;
        step();
        kill_in = '0;
        exp_kc++;
        t_kill1 = cyc;
        checks++;
        if (kill_count !== 8'(exp_kc) || alive_count !== 4'd2) begin
            $display("FAIL kill_slot1 kc=%0d cnt=%0d exp kc=%0d cnt=2",
                     kill_count, alive_count, exp_kc);
            failures++;
        end
        push_exp(3'd3);
        serve(2, 20, 1'b0, 4'b0000, c);
        kill_in = 4'b0001;
        step();
        kill_in = '0;
        exp_kc++;
        push_exp(3'd1);
        serve(2, 200, 1'b0, 4'b0000, c);
        checks++;
        if (c < 0 || c - t_kill1 < 97 || c - t_kill1 > 102) begin
            $display("FAIL respawn_delay cycles=%0d exp 97..102", c - t_kill1);
            failures++;
        end
    endtask

    task automatic test_hold_stable();
        int c;
        kill_in = 4'b1000;
        step();
        kill_in = '0;
        exp_kc++;
        push_exp(3'd0);
        serve(50, 200, 1'b1, 4'b0000, c);
    endtask

    task automatic test_ack_and_kill();
        int c;
        kill_in = 4'b0100;
        step();
        kill_in = '0;
        exp_kc++;
        push_exp(3'd3);
        serve(2, 200, 1'b0, 4'b0000, c);
        kill_in = 4'b0010;
        step();
        kill_in = '0;
        exp_kc++;
        push_exp(3'd2);
        serve(2, 200, 1'b0, 4'b0001, c);
        exp_kc++;
        checks++;
        if (alive_count !== 4'd2 || slot_alive !== 4'b1100 || kill_count !== 8'(exp_kc)) begin
            $display("FAIL ack_with_kill cnt=%0d alive=%b kc=%0d exp 2/1100/%0d",
                     alive_count, slot_alive, kill_count, exp_kc);
            failures++;
        end
    endtask

    task automatic test_is_start_mid();
        int   waited;
        int   c;
        exp_t e;
        bit   saw_valid;
        push_exp(3'd1);
        waited = 0;
        while (spawn_valid !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        e = pop_exp();
        checks++;
        if (spawn_valid !== 1'b1 || spawn_slot !== e.slot || spawn_x !== e.x) begin
            $display("FAIL pre_start_req valid=%b slot=%0d x=%0d exp 1/%0d/%0d",
                     spawn_valid, spawn_slot, spawn_x, e.slot, e.x);
            failures++;
        end
        is_start = 1'b1;
        step();
        checks++;
        if (spawn_valid !== 1'b0 || slot_alive !== 4'b0000 || alive_count !== 4'd0 ||
            kill_count !== 8'(exp_kc)) begin
            $display("FAIL is_start_mid valid=%b alive=%b cnt=%0d kc=%0d exp 0/0000/0/%0d",
                     spawn_valid, slot_alive, alive_count, kill_count, exp_kc);
            failures++;
        end
        saw_valid = 1'b0;
        repeat (5) begin
            step();
            if (spawn_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            $display("FAIL is_start_hold spawn_valid seen=1 required 0");
            failures++;
        end
        // Abandoned request leaves the pointer at 3; timers were cleared.
        is_start = 1'b0;
        push_exp(3'd3);
        push_exp(3'd0);
        push_exp(3'd1);
        for (int i = 0; i < 3; i++) serve(1, 20, 1'b0, 4'b0000, c);
    endtask

    task automatic test_kill_saturate();
        int  raw;
        int  n;
        bit  killed_last;
        raw         = exp_kc;
        n           = 0;
        killed_last = 1'b0;
        while (raw < 300 && n < 40000) begin
            spawn_ack = spawn_valid ? (4'b0001 << spawn_slot) : 4'b0000;
            if (!killed_last && slot_alive != 4'b0000) begin
                kill_in     = slot_alive & (~slot_alive + 4'b0001);
                raw++;
                killed_last = 1'b1;
            end else begin
                kill_in     = '0;
                killed_last = 1'b0;
            end
            step();
            n++;
            if (raw == 200) begin
                checks++;
                if (kill_count !== 8'd200) begin
                    $display("FAIL kill_count_mid got=%0d exp=200", kill_count);
                    failures++;
                end
                raw++;
                kill_in = '0;
                spawn_ack = '0;
                step();
                raw--;
            end
        end
        spawn_ack = '0;
        kill_in   = '0;
        step();
        checks++;
        if (raw < 300) begin
            $display("FAIL kill_loop_timeout kills=%0d required 300", raw);
            failures++;
        end
        checks++;
        if (kill_count !== 8'd255) begin
            $display("FAIL kill_saturate got=%0d exp=255", kill_count);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        waited = 0;
        while (spawn_valid !== 1'b1 && waited < 400) begin
            step();
            waited++;
        end
        checks++;
        if (spawn_valid !== 1'b1) begin
            $display("FAIL reset_mid_no_req spawn_valid=%b required 1", spawn_valid);
            failures++;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (spawn_valid !== 1'b0 || kill_count !== 8'd0 || alive_count !== 4'd0) begin
            $display("FAIL reset_mid valid=%b kc=%0d cnt=%0d exp 0/0/0",
                     spawn_valid, kill_count, alive_count);
            failures++;
        end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_initial_spawns();
        test_kill_respawn();
        test_hold_stable();
        test_ack_and_kill();
        test_is_start_mid();
        test_kill_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
